// File: rtl/fastica_pkg.sv
// Shared types and constants for the FastICA sequencer.
// Q13.13 fixed point: 26-bit signed words, 13 fraction bits.
package fastica_pkg;

  localparam int WORD_W = 26;
  localparam int FRAC_W = 13;
  localparam logic signed [WORD_W-1:0] ONE_Q = 26'sd8192;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_UPD,
    ST_ORTH,
    ST_CHK,
    ST_NEXT,
    ST_FIN
  } state_t;

endpackage

// File: rtl/fastica_conv_chk.sv
// Convergence test: |w_new . w_old| >= 1.0 - EPS.
// Either sign counts, because ICA components are sign-ambiguous.
module fastica_conv_chk
  import fastica_pkg::*;
#(
  parameter logic signed [WORD_W-1:0] EPS = 26'sd8
) (
  input  logic [WORD_W-1:0] dot,
  output logic              conv
);

  localparam logic signed [WORD_W:0] THR =
    (WORD_W+1)'(ONE_Q) - (WORD_W+1)'(EPS);

  logic signed [WORD_W:0] ext;
  logic signed [WORD_W:0] mag;

  // One extra bit so the most negative input has a representable magnitude.
  always_comb begin
    ext  = {dot[WORD_W-1], dot};
    mag  = ext[WORD_W] ? -ext : ext;
    conv = (mag >= THR);
  end

endmodule

// File: rtl/fastica_seq_ctrl.sv
// FastICA extraction sequencer: loads W, then runs update,
// decorrelation and convergence check per component row.
module fastica_seq_ctrl
  import fastica_pkg::*;
#(
  parameter int NCOMP = 4,
  parameter int MAX_ITER = 64,
  parameter int ITER_W = 7,
  parameter logic signed [WORD_W-1:0] EPS = 26'sd8
) (
  input  logic              clk_c,
  input  logic              rstn_c,
  input  logic              start,
  output logic              en_b,
  output logic              upd_start,
  input  logic              upd_done,
  output logic              orth_start,
  input  logic              orth_done,
  input  logic              dot_valid,
  input  logic [WORD_W-1:0] dot_in,
  output logic [1:0]        comp_idx,
  output logic [ITER_W-1:0] iter_cnt,
  output logic [NCOMP-1:0]  conv_mask,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  localparam logic [ITER_W-1:0] LAST_IT = ITER_W'(MAX_ITER - 1);
  localparam logic [1:0] LAST_CMP = 2'(NCOMP - 1);

  state_t state;
  state_t state_d;

  logic conv;
  logic start_acc;
  logic dot_acc;
  logic next_acc;
  logic last_iter;
  logic last_comp;

  fastica_conv_chk #(
    .EPS (EPS)
  ) u_conv (
    .dot  (dot_in),
    .conv (conv)
  );

  assign last_iter = (iter_cnt == LAST_IT);
  assign last_comp = (comp_idx == LAST_CMP);

  always_comb begin
    state_d   = state;
    start_acc = 1'b0;
    dot_acc   = 1'b0;
    next_acc  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_UPD;
      // Done strobes are ignored while our own start pulse is out.
      ST_UPD: begin
        if (upd_done && !upd_start) state_d = ST_ORTH;
      end
      ST_ORTH: begin
        if (orth_done && !orth_start) state_d = ST_CHK;
      end
      ST_CHK: begin
        if (dot_valid) begin
          dot_acc = 1'b1;
          if (conv || last_iter) state_d = ST_NEXT;
          else                   state_d = ST_UPD;
        end
      end
      ST_NEXT: begin
        next_acc = 1'b1;
        state_d  = last_comp ? ST_FIN : ST_UPD;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_c or negedge rstn_c) begin
    if (!rstn_c) begin
      state      <= ST_IDLE;
      en_b       <= 1'b0;
      upd_start  <= 1'b0;
      orth_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      comp_idx   <= '0;
      iter_cnt   <= '0;
      conv_mask  <= '0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_d;
      en_b       <= (state_d == ST_LOAD);
      upd_start  <= (state_d == ST_UPD) && (state != ST_UPD);
      orth_start <= (state_d == ST_ORTH) && (state != ST_ORTH);
      busy       <= (state_d != ST_IDLE);
      done       <= (state_d == ST_FIN);
      unique case (1'b1)
        start_acc: begin
          comp_idx  <= '0;
          iter_cnt  <= '0;
          conv_mask <= '0;
          timeout   <= 1'b0;
        end
        dot_acc: begin
          iter_cnt <= iter_cnt + 1'b1;
          if (conv)           conv_mask[comp_idx] <= 1'b1;
          else if (last_iter) timeout <= 1'b1;
        end
        next_acc: begin
          if (!last_comp) begin
            comp_idx <= comp_idx + 1'b1;
            iter_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fastica_seq_ctrl.sv
// Scoreboard bench for fastica_seq_ctrl with behavioural
// update/decorrelation units that answer after 5 cycles.
module tb_fastica_seq_ctrl;

  logic        clk_c;
  logic        rstn_c;
  logic        start;
  logic        en_b;
  logic        upd_start;
  logic        upd_done;
  logic        orth_start;
  logic        orth_done;
  logic        dot_valid;
  logic [25:0] dot_in;
  logic [1:0]  comp_idx;
  logic [6:0]  iter_cnt;
  logic [3:0]  conv_mask;
  logic        busy;
  logic        done;
  logic        timeout;

  logic upd_done_auto;
  logic upd_done_man;
  assign upd_done = upd_done_auto | upd_done_man;

  fastica_seq_ctrl dut (
    .clk_c      (clk_c),
    .rstn_c     (rstn_c),
    .start      (start),
    .en_b       (en_b),
    .upd_start  (upd_start),
    .upd_done   (upd_done),
    .orth_start (orth_start),
    .orth_done  (orth_done),
    .dot_valid  (dot_valid),
    .dot_in     (dot_in),
    .comp_idx   (comp_idx),
    .iter_cnt   (iter_cnt),
    .conv_mask  (conv_mask),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout)
  );

  initial clk_c = 1'b0;
  always #5 clk_c = ~clk_c;

  typedef struct {
    logic [3:0] mask;
    logic [6:0] iter;
    logic       tmo;
    int         n_upd;
    int         n_orth;
    int         n_en;
  } exp_t;

  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  int n_en = 0;
  int n_upd = 0;
  int n_orth = 0;
  int done_cnt = 0;

  // dot response plan: written by main, consumed by the orth unit
  logic signed [25:0] dot_seq [0:7];
  int seq_base = 0;
  int seq_len = 0;
  logic signed [25:0] dot_def = 26'sd8190;
  int dot_limit = -1;
  int dots_given = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // monitor: pulse counting plus scoreboard pop on done
  always @(negedge clk_c) begin
    if (en_b) n_en++;
    if (upd_start) n_upd++;
    if (orth_start) n_orth++;
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1 want no done");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("fin_conv_mask", 32'(conv_mask), 32'(e.mask));
        chk("fin_iter_cnt", 32'(iter_cnt), 32'(e.iter));
        chk("fin_timeout", 32'(timeout), 32'(e.tmo));
        chk("fin_comp_idx", 32'(comp_idx), 32'd3);
        chk("fin_busy", 32'(busy), 32'd1);
        chk("fin_n_upd", 32'(n_upd), 32'(e.n_upd));
        chk("fin_n_orth", 32'(n_orth), 32'(e.n_orth));
        chk("fin_n_en", 32'(n_en), 32'(e.n_en));
      end
    end
  end

  // behavioural update unit
  initial begin : upd_unit
    upd_done_auto = 1'b0;
    forever begin
      @(negedge clk_c);
      if (upd_start) begin
        repeat (4) @(negedge clk_c);
        upd_done_auto = 1'b1;
        @(negedge clk_c);
        upd_done_auto = 1'b0;
      end
    end
  end

  // behavioural decorrelation unit followed by the dot product
  initial begin : orth_unit
    orth_done = 1'b0;
    dot_valid = 1'b0;
    dot_in    = '0;
    forever begin
      @(negedge clk_c);
      if (orth_start) begin
        repeat (4) @(negedge clk_c);
        orth_done = 1'b1;
        @(negedge clk_c);
        orth_done = 1'b0;
        if (dot_limit < 0 || dots_given < dot_limit) begin
          int idx;
          idx = dots_given - seq_base;
          dot_in = (idx < seq_len) ? dot_seq[idx] : dot_def;
          dots_given++;
          dot_valid = 1'b1;
          @(negedge clk_c);
          dot_valid = 1'b0;
        end
      end
    end
  end

  task automatic wait_done(input int lim);
    int base;
    int n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < lim) begin
      @(negedge clk_c);
      n++;
    end
    if (done_cnt == base) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_done: got no done in %0d cycles want done", lim);
    end
    @(negedge clk_c);
  endtask

  task automatic kick(input exp_t e);
    exp_t x;
    x = e;
    x.n_upd  = e.n_upd + n_upd;
    x.n_orth = e.n_orth + n_orth;
    x.n_en   = e.n_en + n_en;
    sb.push_back(x);
    @(negedge clk_c);
    start = 1'b1;
    @(negedge clk_c);
    chk("en_b_latency", 32'(en_b), 32'd1);
    chk("busy_on_load", 32'(busy), 32'd1);
    start = 1'b0;
    @(negedge clk_c);
    chk("upd_start_latency", 32'(upd_start), 32'd1);
    chk("en_b_single", 32'(en_b), 32'd0);
  endtask

  task automatic run(input exp_t e, input int lim);
    kick(e);
    wait_done(lim);
  endtask

  task automatic wait_orth(input int target, input int lim);
    int n;
    n = 0;
    while (n_orth < target && n < lim) begin
      @(negedge clk_c);
      n++;
    end
    if (n_orth < target) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_orth: got %0d orth starts want %0d", n_orth, target);
    end
  endtask

  initial begin : main
    exp_t e;
    rstn_c = 1'b0;
    start = 1'b0;
    upd_done_man = 1'b0;
    repeat (3) @(negedge clk_c);
    chk("rst_en_b", 32'(en_b), 32'd0);
    chk("rst_upd_start", 32'(upd_start), 32'd0);
    chk("rst_orth_start", 32'(orth_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_comp_idx", 32'(comp_idx), 32'd0);
    chk("rst_iter_cnt", 32'(iter_cnt), 32'd0);
    chk("rst_conv_mask", 32'(conv_mask), 32'd0);
    rstn_c = 1'b1;
    repeat (2) @(negedge clk_c);

    // all rows converge on first check
    dot_def = 26'sd8190;
    e = '{mask: 4'hF, iter: 7'd1, tmo: 1'b0, n_upd: 4, n_orth: 4, n_en: 1};
    run(e, 1000);

    // threshold boundaries and most negative input
    dot_seq[0] = -26'sd8188;
    dot_seq[1] = 26'sd8183;
    dot_seq[2] = 26'sd8184;
    dot_seq[3] = 26'h2000000;
    seq_base = dots_given;
    seq_len = 4;
    e = '{mask: 4'hF, iter: 7'd1, tmo: 1'b0, n_upd: 5, n_orth: 5, n_en: 1};
    run(e, 1000);
    seq_len = 0;

    // never converges: every row hits the iteration limit
    dot_def = 26'sd4096;
    e = '{mask: 4'h0, iter: 7'd64, tmo: 1'b1, n_upd: 256, n_orth: 256,
          n_en: 1};
    run(e, 8000);
    repeat (3) @(negedge clk_c);
    chk("hold_timeout", 32'(timeout), 32'd1);
    chk("hold_iter_cnt", 32'(iter_cnt), 32'd64);
    chk("hold_busy", 32'(busy), 32'd0);

    // spurious upd_done in ORTH and start while busy
    dot_def = 26'sd8190;
    e = '{mask: 4'hF, iter: 7'd1, tmo: 1'b0, n_upd: 4, n_orth: 4, n_en: 1};
    fork
      run(e, 1000);
      begin
        wait_orth(n_orth + 1, 200);
        @(negedge clk_c);
        upd_done_man = 1'b1;
        start = 1'b1;
        @(negedge clk_c);
        upd_done_man = 1'b0;
        start = 1'b0;
      end
    join
    repeat (3) @(negedge clk_c);

    // reset while stalled in CHK on row 2
    dot_limit = dots_given + 2;
    @(negedge clk_c);
    start = 1'b1;
    @(negedge clk_c);
    start = 1'b0;
    wait_orth(n_orth + 3, 500);
    repeat (8) @(negedge clk_c);
    chk("stall_comp_idx", 32'(comp_idx), 32'd2);
    chk("stall_busy", 32'(busy), 32'd1);
    chk("stall_conv_mask", 32'(conv_mask), 32'h3);
    #2 rstn_c = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_comp_idx", 32'(comp_idx), 32'd0);
    chk("arst_conv_mask", 32'(conv_mask), 32'd0);
    chk("arst_iter_cnt", 32'(iter_cnt), 32'd0);
    chk("arst_timeout", 32'(timeout), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(negedge clk_c);
    rstn_c = 1'b1;
    dot_limit = -1;
    repeat (2) @(negedge clk_c);
    e = '{mask: 4'hF, iter: 7'd1, tmo: 1'b0, n_upd: 4, n_orth: 4, n_en: 1};
    run(e, 1000);

    repeat (5) @(negedge clk_c);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
